rr_hold_arb: RTL and testbench

Round-robin arbiter that shares one bus resource between `N` requesters. Each grant is held while the owner keeps its request asserted. If the owner exceeds a configurable hold limit, it is forcibly preempted. A one-cycle dead gap is inserted between owners so the bus never has two drivers. It sits in front of the shared bus, driven directly by the requesting blocks.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 32 +++
 rtl/rr_hold_arb.sv | 128 ++++++++++++
 tb/tb_rr_hold_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWN, GAP)
//   onehot_of   : index -> one-hot vector, MAX_N bits wide; callers truncate to N
package arb_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Returns a MAX_N-wide vector with only bit idx set.
  function automatic logic [MAX_N-1:0] onehot_of(input logic [3:0] idx);
    logic [MAX_N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req   : request vector, bit i = requester i
//   ptr   : index with highest priority this pick
//   valid : at least one request is set
//   idx   : first set request found scanning ptr, ptr+1, ... modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest set request
  // (lowest offset from ptr) is the last assignment and therefore wins.
  always_comb begin
    int pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = (int'(ptr) + off) % N;
      if (req[pos]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/rr_hold_arb.sv
// Round-robin arbiter for one shared bus with grant holding, a hold limit
// with forced preemption, and a one-cycle dead gap between owners.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   req      : level requests, bit i = requester i
//   grant    : registered one-hot grant, or all zero
//   grant_id : index of the current owner, 0 when not busy
//   busy     : registered, equals |grant
//   timeout  : one-cycle pulse in the dead cycle after a hold-limit preemption
module rr_hold_arb
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          timeout
);

  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  logic          limit_hit;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign next_ptr  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state logic. The owner register doubles as grant_id, so it is
  // cleared whenever ownership ends to keep grant_id at 0 while idle.
  // Release is checked before the hold limit so a simultaneous drop of
  // the request counts as a normal release without a timeout pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d = OWN;
          owner_d = pick_idx;
          grant_d = N'(onehot_of(4'(pick_idx)));
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          owner_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      OWN: begin
        if (!req[owner_q] || limit_hit) begin
          state_d   = GAP;
          ptr_d     = next_ptr;
          owner_d   = '0;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          timeout_d = req[owner_q];
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = owner_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_hold_arb.sv
// Directed testbench for rr_hold_arb. Three instances share clock and reset:
// dutA (MAX_HOLD=16), dutB (MAX_HOLD=4), dutC (MAX_HOLD=0, no limit).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rr_hold_arb;

  logic       clk;
  logic       reset;
  logic [3:0] reqA, reqB, reqC;
  logic [3:0] grantA, grantB, grantC;
  logic [1:0] idA, idB, idC;
  logic       busyA, busyB, busyC;
  logic       toA, toB, toC;

  int checks = 0;
  int errors = 0;

  rr_hold_arb #(.N(4), .MAX_HOLD(16)) dutA (
    .clk(clk), .reset(reset), .req(reqA), .grant(grantA),
    .grant_id(idA), .busy(busyA), .timeout(toA)
  );

  rr_hold_arb #(.N(4), .MAX_HOLD(4)) dutB (
    .clk(clk), .reset(reset), .req(reqB), .grant(grantB),
    .grant_id(idB), .busy(busyB), .timeout(toB)
  );

  rr_hold_arb #(.N(4), .MAX_HOLD(0)) dutC (
    .clk(clk), .reset(reset), .req(reqC), .grant(grantC),
    .grant_id(idC), .busy(busyC), .timeout(toC)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Brings all instances back to IDLE with ptr=0; returns on a falling
  // edge with reset released and all requests low.
  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    reqA = '0; reqB = '0; reqC = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    reqA = '0; reqB = '0; reqC = '0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (grantA !== 4'b0000 || busyA !== 1'b0 || idA !== 2'd0 || toA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: got grant=%b busy=%b id=%0d to=%b want 0000/0/0/0", grantA, busyA, idA, toA);
    end
    @(negedge clk);
    reset = 1'b1;
    reqA  = 4'b0100;
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0100 || idA !== 2'd2 || busyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got grant=%b id=%0d busy=%b want 0100/2/1", grantA, idA, busyA);
    end
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (grantA !== 4'b0000 || busyA !== 1'b0 || idA !== 2'd0 || toA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got grant=%b busy=%b id=%0d to=%b want 0000/0/0/0", grantA, busyA, idA, toA);
    end
    @(negedge clk);
    reset = 1'b1;
    reqA  = 4'b1111;
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0001 || idA !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_ptr_cleared: got grant=%b id=%0d want 0001/0", grantA, idA);
    end
    reqA = 4'b0000;
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0000 || busyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got grant=%b busy=%b want 0000/0", grantA, busyA);
    end
  endtask

  task automatic test_rr_sweep();
    logic [3:0] expGrant;
    pulseReset();
    reqA = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expGrant = 4'(1 << (k % 4));
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (grantA !== expGrant || idA !== 2'(k % 4) || busyA !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sweep_grant k=%0d c=%0d: got grant=%b id=%0d busy=%b want %b/%0d/1", k, c, grantA, idA, busyA, expGrant, k % 4);
        end
      end
      reqA = 4'b1111 & ~expGrant;
      @(negedge clk);
      checks++;
      if (grantA !== 4'b0000 || busyA !== 1'b0 || toA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_gap k=%0d: got grant=%b busy=%b to=%b want 0000/0/0", k, grantA, busyA, toA);
      end
      reqA = 4'b1111;
    end
    reqA = 4'b0000;
  endtask

  task automatic test_preempt();
    pulseReset();
    reqA = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++;
        if (grantA !== 4'(1 << r) || toA !== 1'b0) begin
          errors++;
          $display("[TB] FAIL preempt_hold r=%0d c=%0d: got grant=%b to=%b want %b/0", r, c, grantA, toA, 4'(1 << r));
        end
      end
      @(negedge clk);
      checks++;
      if (grantA !== 4'b0000 || toA !== 1'b1 || busyA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL preempt_timeout r=%0d: got grant=%b to=%b busy=%b want 0000/1/0", r, grantA, toA, busyA);
      end
    end
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0001 || toA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL preempt_wrap: got grant=%b to=%b want 0001/0", grantA, toA);
    end
    reqA = 4'b0000;
  endtask

  task automatic test_sole_regrant();
    pulseReset();
    reqB = 4'b0100;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (grantB !== 4'b0100 || idB !== 2'd2 || toB !== 1'b0) begin
          errors++;
          $display("[TB] FAIL sole_hold r=%0d c=%0d: got grant=%b id=%0d to=%b want 0100/2/0", r, c, grantB, idB, toB);
        end
      end
      @(negedge clk);
      checks++;
      if (grantB !== 4'b0000 || toB !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sole_timeout r=%0d: got grant=%b to=%b want 0000/1", r, grantB, toB);
      end
    end
    reqB = 4'b0000;
  endtask

  task automatic test_release_at_limit();
    pulseReset();
    reqB = 4'b1000;
    repeat (4) @(negedge clk);
    checks++;
    if (grantB !== 4'b1000 || idB !== 2'd3) begin
      errors++;
      $display("[TB] FAIL limit_last_cycle: got grant=%b id=%0d want 1000/3", grantB, idB);
    end
    reqB = 4'b0000;
    @(negedge clk);
    checks++;
    if (grantB !== 4'b0000 || toB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limit_release_no_timeout: got grant=%b to=%b want 0000/0", grantB, toB);
    end
  endtask

  task automatic test_non_owner();
    pulseReset();
    reqA = 4'b0010;
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0010 || idA !== 2'd1) begin
      errors++;
      $display("[TB] FAIL nonowner_first: got grant=%b id=%0d want 0010/1", grantA, idA);
    end
    reqA = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (grantA !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL nonowner_held c=%0d: got grant=%b want 0010", c, grantA);
      end
    end
    reqA = 4'b1000;
    @(negedge clk);
    checks++;
    if (grantA !== 4'b0000 || busyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nonowner_gap: got grant=%b busy=%b want 0000/0", grantA, busyA);
    end
    @(negedge clk);
    checks++;
    if (grantA !== 4'b1000 || idA !== 2'd3 || busyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonowner_handover: got grant=%b id=%0d busy=%b want 1000/3/1", grantA, idA, busyA);
    end
    reqA = 4'b0000;
  endtask

  task automatic test_no_limit();
    int bad;
    pulseReset();
    reqC = 4'b0001;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if (grantC !== 4'b0001 || toC !== 1'b0 || busyC !== 1'b1) begin
        errors++;
        if (bad < 5)
          $display("[TB] FAIL nolimit_hold c=%0d: got grant=%b to=%b busy=%b want 0001/0/1", c, grantC, toC, busyC);
        bad++;
      end
    end
    reqC = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (grantC !== 4'b0000 || busyC !== 1'b0 || idC !== 2'd0 || toC !== 1'b0) begin
        errors++;
        $display("[TB] FAIL nolimit_release c=%0d: got grant=%b busy=%b id=%0d to=%b want 0000/0/0/0", c, grantC, busyC, idC, toC);
      end
    end
    reqC = 4'b0010;
    @(negedge clk);
    checks++;
    if (grantC !== 4'b0010 || idC !== 2'd1) begin
      errors++;
      $display("[TB] FAIL nolimit_idle_regrant: got grant=%b id=%0d want 0010/1", grantC, idC);
    end
    reqC = 4'b0000;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_rr_sweep();
    test_preempt();
    test_sole_regrant();
    test_release_at_limit();
    test_non_owner();
    test_no_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
